// File: rtl/kmac_digest_stream.sv
// Squeeze-phase digest streamer: unmasks the Keccak state and emits rate words over valid/ready,
// requesting extra permutations when the digest is longer than one rate block.
module kmac_digest_stream #(
  parameter bit          EnMasking = 1'b0,
  parameter int unsigned LenW      = 16,
  localparam int unsigned Share    = EnMasking ? 2 : 1
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        start_i,
  input  logic                        clear_i,
  input  logic [2:0]                  strength_i,
  input  logic [LenW-1:0]             digest_len_i,
  input  logic                        endian_swap_i,
  input  logic [Share-1:0][1599:0]    state_i,
  input  logic                        state_valid_i,
  output logic                        run_o,
  output logic                        out_valid_o,
  output logic [31:0]                 out_data_o,
  output logic                        out_last_o,
  input  logic                        out_ready_i,
  output logic                        done_o,
  output logic                        error_o
);

  localparam int unsigned IdxW = $clog2(42 + 1);
  localparam int unsigned OffW = IdxW + 5;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_STREAM = 2'd1;
  localparam logic [1:0] ST_WAIT   = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  function automatic logic [IdxW-1:0] rate_of(input logic [2:0] s);
    case (s)
      3'b000:  rate_of = IdxW'(42);
      3'b001:  rate_of = IdxW'(36);
      3'b010:  rate_of = IdxW'(34);
      3'b011:  rate_of = IdxW'(26);
      default: rate_of = IdxW'(18);
    endcase
  endfunction

  function automatic logic [31:0] conv_endian32(input logic [31:0] d, input logic sw);
    conv_endian32 = sw ? {d[7:0], d[15:8], d[23:16], d[31:24]} : d;
  endfunction

  logic [1:0]      r_state;
  logic [IdxW-1:0] r_idx;
  logic [IdxW-1:0] r_rate;
  logic [LenW-1:0] r_rem;
  logic            r_valid;
  logic [31:0]     r_data;
  logic            r_last;
  logic            r_run;
  logic            r_done;
  logic            r_error;

  logic [1:0]      w_state_d;
  logic [IdxW-1:0] w_idx_d;
  logic [IdxW-1:0] w_rate_d;
  logic [LenW-1:0] w_rem_d;
  logic            w_valid_d;
  logic [31:0]     w_data_d;
  logic            w_last_d;
  logic            w_run_d;
  logic            w_done_d;
  logic            w_error_d;

  logic [IdxW-1:0] w_next_idx;
  logic [OffW-1:0] w_next_off;
  logic [31:0]     w_word0;
  logic [31:0]     w_wordn;
  logic            w_hs;
  logic            w_str_ok;

  assign w_next_idx = r_idx + IdxW'(1);
  assign w_next_off = {w_next_idx, 5'b0};
  assign w_hs       = r_valid & out_ready_i;
  assign w_str_ok   = (strength_i <= 3'b100);

  // Unmask word 0 (block entry) and the word following the one on the bus
  always_comb begin : unmask
    w_word0 = '0;
    w_wordn = '0;
    for (int unsigned s = 0; s < Share; s++) begin
      w_word0 = w_word0 ^ state_i[s][31:0];
      w_wordn = w_wordn ^ state_i[s][w_next_off +: 32];
    end
  end

  always_comb begin : next_state
    w_state_d = r_state;
    w_idx_d   = r_idx;
    w_rate_d  = r_rate;
    w_rem_d   = r_rem;
    w_valid_d = r_valid;
    w_data_d  = r_data;
    w_last_d  = r_last;
    w_run_d   = 1'b0;
    w_done_d  = 1'b0;
    w_error_d = 1'b0;
    if (clear_i) begin
      w_state_d = ST_IDLE;
      w_valid_d = 1'b0;
      w_last_d  = 1'b0;
      w_idx_d   = '0;
      w_rem_d   = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start_i) begin
            if (!w_str_ok) begin
              w_error_d = 1'b1;
            end else if (digest_len_i == '0) begin
              w_done_d = 1'b1;
            end else begin
              w_state_d = ST_STREAM;
              w_idx_d   = '0;
              w_rem_d   = digest_len_i;
              w_rate_d  = rate_of(strength_i);
              w_valid_d = 1'b1;
              w_data_d  = conv_endian32(w_word0, endian_swap_i);
              w_last_d  = (digest_len_i == LenW'(1));
            end
          end
        end
        ST_STREAM: begin
          if (w_hs) begin
            w_rem_d = r_rem - LenW'(1);
            w_idx_d = w_next_idx;
            if (r_last) begin
              w_state_d = ST_DONE;
              w_valid_d = 1'b0;
              w_last_d  = 1'b0;
              w_done_d  = 1'b1;
            end else if (w_next_idx == r_rate) begin
              // Rate block exhausted with words still owed: ask for another permutation
              w_state_d = ST_WAIT;
              w_valid_d = 1'b0;
              w_run_d   = 1'b1;
            end else begin
              w_data_d = conv_endian32(w_wordn, endian_swap_i);
              w_last_d = (r_rem == LenW'(2));
            end
          end
        end
        ST_WAIT: begin
          if (state_valid_i) begin
            w_state_d = ST_STREAM;
            w_idx_d   = '0;
            w_valid_d = 1'b1;
            w_data_d  = conv_endian32(w_word0, endian_swap_i);
            w_last_d  = (r_rem == LenW'(1));
          end
        end
        ST_DONE: w_state_d = ST_IDLE;
        default: w_state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin : regs
    if (!rst_ni) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_rate  <= '0;
      r_rem   <= '0;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_last  <= 1'b0;
      r_run   <= 1'b0;
      r_done  <= 1'b0;
      r_error <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_idx   <= w_idx_d;
      r_rate  <= w_rate_d;
      r_rem   <= w_rem_d;
      r_valid <= w_valid_d;
      r_data  <= w_data_d;
      r_last  <= w_last_d;
      r_run   <= w_run_d;
      r_done  <= w_done_d;
      r_error <= w_error_d;
    end
  end

  assign run_o       = r_run;
  assign out_valid_o = r_valid;
  assign out_data_o  = r_data;
  assign out_last_o  = r_last;
  assign done_o      = r_done;
  assign error_o     = r_error;

endmodule

// File: tb/tb_kmac_digest_stream.sv
// Bench for kmac_digest_stream: a word-list model of the digest is compared against the bus every cycle.
module tb_kmac_digest_stream;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } exp_t;

  logic                  clk_i = 1'b0;
  logic                  rst_ni;
  logic                  start_i;
  logic                  clear_i;
  logic [2:0]            strength_i;
  logic [15:0]           digest_len_i;
  logic                  endian_swap_i;
  logic [1:0][1599:0]    state_i;
  logic                  state_valid_i;
  logic                  run_o;
  logic                  out_valid_o;
  logic [31:0]           out_data_o;
  logic                  out_last_o;
  logic                  out_ready_i;
  logic                  done_o;
  logic                  error_o;

  int   checks = 0;
  int   errors = 0;
  int   cnt_run = 0;
  int   cnt_done = 0;
  int   cnt_err = 0;
  exp_t exp_q[$];

  kmac_digest_stream #(.EnMasking(1'b1), .LenW(16)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .clear_i(clear_i),
    .strength_i(strength_i), .digest_len_i(digest_len_i), .endian_swap_i(endian_swap_i),
    .state_i(state_i), .state_valid_i(state_valid_i), .run_o(run_o),
    .out_valid_o(out_valid_o), .out_data_o(out_data_o), .out_last_o(out_last_o),
    .out_ready_i(out_ready_i), .done_o(done_o), .error_o(error_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic int rate_words(input logic [2:0] s);
    case (s)
      3'b000:  return 42;
      3'b001:  return 36;
      3'b010:  return 34;
      3'b011:  return 26;
      default: return 18;
    endcase
  endfunction

  // Intended unmasked value of word w of permutation output b
  function automatic logic [31:0] unm(input logic [31:0] seed, input int b, input int w);
    return seed ^ {16'(b), 16'(w)};
  endfunction

  function automatic logic [31:0] swap32(input logic [31:0] x, input logic sw);
    logic [31:0] y;
    y = {<<8{x}};
    return sw ? y : x;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic build_model(input logic [2:0] str, input int len, input logic [31:0] seed,
                             input logic sw);
    int rate;
    exp_t e;
    rate = rate_words(str);
    for (int k = 0; k < len; k++) begin
      e.data = swap32(unm(seed, k / rate, k % rate), sw);
      e.last = (k == len - 1);
      exp_q.push_back(e);
    end
  endtask

  // Random share 1, share 0 chosen so the XOR gives the intended value
  task automatic load_block(input logic [31:0] seed, input int b);
    logic [31:0] r;
    for (int w = 0; w < 50; w++) begin
      r = $urandom;
      state_i[1][32*w +: 32] = r;
      state_i[0][32*w +: 32] = unm(seed, b, w) ^ r;
    end
  endtask

  task automatic pulse_start(input logic [2:0] str, input int len, input logic sw);
    strength_i    = str;
    digest_len_i  = 16'(len);
    endian_swap_i = sw;
    start_i       = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
  endtask

  // Start a digest and serve run_o requests until done_o, then check pulse counts
  task automatic drive_digest(input string name, input logic [2:0] str, input int len,
                              input logic sw, input logic [31:0] seed, input bit toggle,
                              input int exp_runs);
    int blk, cyc, r0, d0;
    bit fin;
    r0 = cnt_run; d0 = cnt_done; blk = 0; cyc = 0; fin = 1'b0;
    out_ready_i = toggle ? 1'b0 : 1'b1;
    pulse_start(str, len, sw);
    while (!fin && cyc < 3000) begin
      if (toggle) out_ready_i = ~out_ready_i;
      if (run_o) begin
        blk++;
        repeat (5) @(posedge clk_i);
        #1;
        load_block(seed, blk);
        state_valid_i = 1'b1;
        @(posedge clk_i); #1;
        state_valid_i = 1'b0;
        cyc += 6;
      end else if (done_o) begin
        fin = 1'b1;
      end else begin
        @(posedge clk_i); #1;
        cyc++;
      end
    end
    out_ready_i = 1'b1;
    @(negedge clk_i); #1;
    check({name, "_done_seen"}, 32'(fin), 32'd1);
    check({name, "_run_count"}, 32'(cnt_run - r0), 32'(exp_runs));
    check({name, "_done_count"}, 32'(cnt_done - d0), 32'd1);
    check({name, "_words_left"}, 32'(exp_q.size()), 32'd0);
    @(posedge clk_i); #1;
  endtask

  // Per-cycle comparison of the bus against the head of the expected word list
  always @(negedge clk_i) begin
    if (rst_ni) begin
      if (run_o)    cnt_run++;
      if (done_o)   cnt_done++;
      if (error_o)  cnt_err++;
      if (out_valid_o) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL spurious_word: got data %h last %b expected no valid word",
                   out_data_o, out_last_o);
        end else begin
          if (out_data_o !== exp_q[0].data || out_last_o !== exp_q[0].last) begin
            errors++;
            $display("FAIL word: got data %h last %b expected data %h last %b",
                     out_data_o, out_last_o, exp_q[0].data, exp_q[0].last);
          end
          if (out_ready_i) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    int c0, d0, e0, cyc;
    rst_ni = 1'b0; start_i = 1'b0; clear_i = 1'b0; strength_i = 3'b000; digest_len_i = '0;
    endian_swap_i = 1'b0; state_i = '0; state_valid_i = 1'b0; out_ready_i = 1'b1;
    repeat (3) @(negedge clk_i);
    check("rst_valid", 32'(out_valid_o), 32'd0);
    check("rst_data", out_data_o, 32'd0);
    check("rst_last", 32'(out_last_o), 32'd0);
    check("rst_run", 32'(run_o), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_error", 32'(error_o), 32'd0);
    #1 rst_ni = 1'b1;
    @(posedge clk_i); #1;

    // L256 len 8, word k = k
    build_model(3'b010, 8, 32'h0, 1'b0);
    check("model_l256_w7", exp_q[7].data, 32'h0000_0007);
    check("model_l256_last", 32'(exp_q[7].last), 32'd1);
    load_block(32'h0, 0);
    drive_digest("l256", 3'b010, 8, 1'b0, 32'h0, 1'b0, 0);

    // L512 len 20: one extra permutation
    build_model(3'b100, 20, 32'h0, 1'b0);
    check("model_l512_w18", exp_q[18].data, 32'h0001_0000);
    check("model_l512_w19", exp_q[19].data, 32'h0001_0001);
    load_block(32'h0, 0);
    drive_digest("l512", 3'b100, 20, 1'b0, 32'h0, 1'b0, 1);

    // Masked unmask plus byte swap, literal expectation
    state_i = '0;
    state_i[0][31:0] = 32'hA5A5_A5A5;
    state_i[1][31:0] = 32'hFFFF_0000;
    exp_q.push_back('{data: 32'hA5A5_5A5A, last: 1'b1});
    drive_digest("masked_swap", 3'b010, 1, 1'b1, 32'h0, 1'b0, 0);

    // Back-pressure every other cycle over a full L256 block
    build_model(3'b010, 34, 32'h1234_5678, 1'b1);
    load_block(32'h1234_5678, 0);
    drive_digest("toggle", 3'b010, 34, 1'b1, 32'h1234_5678, 1'b1, 0);

    // Rate boundaries for the other strengths
    build_model(3'b001, 36, 32'hCAFE_0000, 1'b0);
    load_block(32'hCAFE_0000, 0);
    drive_digest("l224_exact", 3'b001, 36, 1'b0, 32'hCAFE_0000, 1'b0, 0);
    build_model(3'b011, 27, 32'h5500_AA00, 1'b1);
    load_block(32'h5500_AA00, 0);
    drive_digest("l384_plus1", 3'b011, 27, 1'b1, 32'h5500_AA00, 1'b0, 1);
    build_model(3'b000, 90, 32'hDEAD_BEEF, 1'b0);
    load_block(32'hDEAD_BEEF, 0);
    drive_digest("l128_three", 3'b000, 90, 1'b0, 32'hDEAD_BEEF, 1'b1, 2);

    // Zero length: done only
    drive_digest("len0", 3'b010, 0, 1'b0, 32'h0, 1'b0, 0);

    // Invalid strength: error only
    e0 = cnt_err; d0 = cnt_done;
    pulse_start(3'b101, 4, 1'b0);
    @(negedge clk_i);
    check("bad_str_error", 32'(error_o), 32'd1);
    check("bad_str_valid", 32'(out_valid_o), 32'd0);
    repeat (4) @(posedge clk_i);
    #1;
    check("bad_str_err_count", 32'(cnt_err - e0), 32'd1);
    check("bad_str_no_done", 32'(cnt_done - d0), 32'd0);

    // Clear while streaming
    d0 = cnt_done;
    build_model(3'b010, 10, 32'h0F0F_0000, 1'b0);
    load_block(32'h0F0F_0000, 0);
    out_ready_i = 1'b1;
    pulse_start(3'b010, 10, 1'b0);
    repeat (3) @(posedge clk_i);
    #1 clear_i = 1'b1;
    @(posedge clk_i); #1;
    clear_i = 1'b0;
    exp_q.delete();
    @(negedge clk_i);
    check("clr_stream_valid", 32'(out_valid_o), 32'd0);
    repeat (4) @(posedge clk_i);
    #1;
    check("clr_stream_no_done", 32'(cnt_done - d0), 32'd0);

    // Clear while waiting for the next permutation; late state_valid_i must be ignored
    d0 = cnt_done; c0 = cnt_run;
    build_model(3'b100, 20, 32'h7777_0000, 1'b0);
    load_block(32'h7777_0000, 0);
    pulse_start(3'b100, 20, 1'b0);
    cyc = 0;
    while (!run_o && cyc < 200) begin
      @(posedge clk_i); #1;
      cyc++;
    end
    check("clr_wait_run_seen", 32'(run_o), 32'd1);
    clear_i = 1'b1;
    @(posedge clk_i); #1;
    clear_i = 1'b0;
    exp_q.delete();
    state_valid_i = 1'b1;
    @(posedge clk_i); #1;
    state_valid_i = 1'b0;
    @(negedge clk_i);
    check("clr_wait_valid", 32'(out_valid_o), 32'd0);
    repeat (4) @(posedge clk_i);
    #1;
    check("clr_wait_no_done", 32'(cnt_done - d0), 32'd0);
    check("clr_wait_run_count", 32'(cnt_run - c0), 32'd1);

    // Normal operation after clears
    build_model(3'b010, 8, 32'h0, 1'b1);
    load_block(32'h0, 0);
    drive_digest("after_clear", 3'b010, 8, 1'b1, 32'h0, 1'b0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
